// File: rtl/dma_controller_if.sv
// Signal bundle between the DMA engine, the CPU's DMA port, data memory and
// the device line buffer. The master side is the DMA engine.
interface dma_controller_if #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 3
);
    localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    logic                            dma_cmd;
    logic                            bus_granted;
    logic                            bus_request;
    logic                            dma_end;
    logic                            mem_writeM;
    logic [WORD_SIZE-1:0]            mem_address;
    logic [WORD_SIZE*LINE_WORDS-1:0] mem_data;
    logic [IDX_W-1:0]                dev_index;
    logic [WORD_SIZE*LINE_WORDS-1:0] dev_data;

    modport master (
        input  dma_cmd, bus_granted, dev_data,
        output bus_request, dma_end, mem_writeM, mem_address, mem_data, dev_index
    );

    modport slave (
        output dma_cmd, bus_granted, dev_data,
        input  bus_request, dma_end, mem_writeM, mem_address, mem_data, dev_index
    );
endinterface

// File: rtl/dma_controller.sv
// Bus-master DMA engine: on dma_cmd it requests the data-memory bus, copies
// NUM_LINES device lines to memory starting at DMA_BASE, releases the bus and
// pulses dma_end.
//
//   state | meaning
//   IDLE  | waiting for dma_cmd, all outputs low
//   REQ   | bus requested, waiting for (re)grant
//   WRITE | writing line 'line', held for WRITE_LATENCY cycles
//   DONE  | bus released, one-cycle dma_end pulse
module dma_controller #(
    parameter int                   WORD_SIZE     = 16,
    parameter int                   LINE_WORDS    = 4,
    parameter int                   NUM_LINES     = 3,
    parameter logic [WORD_SIZE-1:0] DMA_BASE      = 16'h01F4,
    parameter int                   WRITE_LATENCY = 4
) (
    input  logic             Clk,
    input  logic             Reset_N,
    dma_controller_if.master bus
);
    localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int LAT_W = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;
    localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(NUM_LINES - 1);
    localparam logic [LAT_W-1:0] LAST_LAT  = LAT_W'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

    state_t               state;
    logic [IDX_W-1:0]     line;
    logic [LAT_W-1:0]     lat_cnt;
    logic                 bus_request_r;
    logic                 dma_end_r;
    logic                 mem_writeM_r;
    logic [WORD_SIZE-1:0] mem_address_r;
    logic [IDX_W-1:0]     dev_index_r;

    // Destination word address of a line; wraps at 2^WORD_SIZE.
    function automatic logic [WORD_SIZE-1:0] line_addr(input logic [IDX_W-1:0] l);
        line_addr = DMA_BASE + WORD_SIZE'(l) * WORD_SIZE'(LINE_WORDS);
    endfunction

    // Sequencer: state, line/latency counters and registered outputs, all
    // updated together so outputs always reflect the state being entered.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state         <= IDLE;
            line          <= '0;
            lat_cnt       <= '0;
            bus_request_r <= 1'b0;
            dma_end_r     <= 1'b0;
            mem_writeM_r  <= 1'b0;
            mem_address_r <= '0;
            dev_index_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.dma_cmd) begin
                        state         <= REQ;
                        bus_request_r <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.bus_granted) begin
                        state         <= WRITE;
                        lat_cnt       <= '0;
                        mem_writeM_r  <= 1'b1;
                        dev_index_r   <= line;
                        mem_address_r <= line_addr(line);
                    end
                end
                WRITE: begin
                    if (!bus.bus_granted) begin
                        // Grant loss wins; the current line restarts on regrant.
                        state         <= REQ;
                        lat_cnt       <= '0;
                        mem_writeM_r  <= 1'b0;
                        dev_index_r   <= '0;
                        mem_address_r <= '0;
                    end else if (lat_cnt < LAST_LAT) begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end else if (line == LAST_LINE) begin
                        state         <= DONE;
                        bus_request_r <= 1'b0;
                        mem_writeM_r  <= 1'b0;
                        dma_end_r     <= 1'b1;
                        dev_index_r   <= '0;
                        mem_address_r <= '0;
                    end else begin
                        line          <= line + 1'b1;
                        lat_cnt       <= '0;
                        dev_index_r   <= line + 1'b1;
                        mem_address_r <= line_addr(line + 1'b1);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    line      <= '0;
                    dma_end_r <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    line          <= '0;
                    lat_cnt       <= '0;
                    bus_request_r <= 1'b0;
                    dma_end_r     <= 1'b0;
                    mem_writeM_r  <= 1'b0;
                    mem_address_r <= '0;
                    dev_index_r   <= '0;
                end
            endcase
        end
    end

    assign bus.bus_request = bus_request_r;
    assign bus.dma_end     = dma_end_r;
    assign bus.mem_writeM  = mem_writeM_r;
    assign bus.mem_address = mem_address_r;
    assign bus.dev_index   = dev_index_r;

    // Device data passes straight through while writing so it tracks dev_index
    // in the same cycle; forced low otherwise.
    assign bus.mem_data = mem_writeM_r ? bus.dev_data : '0;
endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: normal transfer, data path, delayed
// grant, grant drop, spurious cmd, mid-transfer reset and address wrap.
module tb_dma_controller;
    localparam logic [63:0] DATA_K = 64'h1111_2222_3333_4444;

    logic Clk;
    logic Reset_N;
    int   n_cmp = 0;
    int   n_err = 0;

    dma_controller_if #(.WORD_SIZE(16), .LINE_WORDS(4), .NUM_LINES(3)) bus  ();
    dma_controller_if #(.WORD_SIZE(16), .LINE_WORDS(4), .NUM_LINES(3)) bus2 ();

    dma_controller #(.DMA_BASE(16'h01F4)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .bus(bus)
    );
    dma_controller #(.DMA_BASE(16'hFFFC)) dut_wrap (
        .Clk(Clk), .Reset_N(Reset_N), .bus(bus2)
    );

    assign bus.dev_data  = DATA_K + 64'(bus.dev_index);
    assign bus2.dev_data = DATA_K + 64'(bus2.dev_index);

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_N = 1'b0;
        bus.dma_cmd = 1'b0;  bus.bus_granted = 1'b0;
        bus2.dma_cmd = 1'b0; bus2.bus_granted = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({bus.bus_request, bus.dma_end, bus.mem_writeM, bus.mem_address, bus.mem_data, bus.dev_index} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: req=%b end=%b wr=%b addr=%h data=%h idx=%0d required all 0",
                     bus.bus_request, bus.dma_end, bus.mem_writeM, bus.mem_address, bus.mem_data, bus.dev_index);
        end
        n_cmp++;
        if ({bus2.bus_request, bus2.dma_end, bus2.mem_writeM, bus2.mem_address, bus2.mem_data, bus2.dev_index} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_wrap: req=%b wr=%b addr=%h required all 0",
                     bus2.bus_request, bus2.mem_writeM, bus2.mem_address);
        end
        Reset_N = 1'b1;
        bus.bus_granted = 1'b1;
        tick();
        n_cmp++;
        if ({bus.bus_request, bus.dma_end, bus.mem_writeM} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_ignores_grant: req/end/wr=%b required 000",
                     {bus.bus_request, bus.dma_end, bus.mem_writeM});
        end
        bus.bus_granted = 1'b0;
    endtask

    task automatic test_normal();
        logic [15:0] ea;
        logic [1:0]  ei;
        bus.dma_cmd = 1'b1;
        tick();                                   // edge 0
        bus.dma_cmd = 1'b0;
        for (int e = 0; e < 2; e++) begin
            n_cmp++;
            if (bus.bus_request !== 1'b1 || bus.mem_writeM !== 1'b0) begin
                n_err++;
                $display("FAIL normal_req_e%0d: req=%b wr=%b required 1/0", e, bus.bus_request, bus.mem_writeM);
            end
            if (e == 0) tick();                   // edge 1, grant still low
        end
        bus.bus_granted = 1'b1;
        for (int e = 2; e <= 13; e++) begin
            tick();
            ei = 2'((e - 2) / 4);
            ea = 16'h01F4 + 16'(4 * ((e - 2) / 4));
            n_cmp++;
            if ({bus.mem_writeM, bus.bus_request, bus.dma_end} !== 3'b110 || bus.mem_address !== ea ||
                bus.dev_index !== ei || bus.mem_data !== DATA_K + 64'(ei)) begin
                n_err++;
                $display("FAIL normal_write_e%0d: wr/req/end=%b addr=%h idx=%0d data=%h required 110 addr=%h idx=%0d data=%h",
                         e, {bus.mem_writeM, bus.bus_request, bus.dma_end}, bus.mem_address, bus.dev_index,
                         bus.mem_data, ea, ei, DATA_K + 64'(ei));
            end
        end
        tick();                                   // edge 14
        n_cmp++;
        if ({bus.dma_end, bus.bus_request, bus.mem_writeM} !== 3'b100) begin
            n_err++;
            $display("FAIL normal_done: end/req/wr=%b required 100", {bus.dma_end, bus.bus_request, bus.mem_writeM});
        end
        bus.bus_granted = 1'b0;
        tick();                                   // edge 15
        n_cmp++;
        if ({bus.bus_request, bus.dma_end, bus.mem_writeM, bus.mem_address, bus.mem_data, bus.dev_index} !== '0) begin
            n_err++;
            $display("FAIL normal_idle: req=%b end=%b wr=%b addr=%h required all 0",
                     bus.bus_request, bus.dma_end, bus.mem_writeM, bus.mem_address);
        end
    endtask

    task automatic test_delayed_grant();
        int bad;
        logic [15:0] ea;
        bus.dma_cmd = 1'b1;
        tick();
        bus.dma_cmd = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.bus_request !== 1'b1 || bus.mem_writeM !== 1'b0) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL delay_wait: %0d bad cycles while waiting for grant, required 0", bad);
        end
        bus.bus_granted = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            ea = 16'h01F4 + 16'(4 * (k / 4));
            if (bus.mem_writeM !== 1'b1 || bus.mem_address !== ea) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL delay_writes: %0d bad write cycles after grant, required 0", bad);
        end
        tick();
        n_cmp++;
        if ({bus.dma_end, bus.bus_request, bus.mem_writeM} !== 3'b100) begin
            n_err++;
            $display("FAIL delay_done: end/req/wr=%b required 100", {bus.dma_end, bus.bus_request, bus.mem_writeM});
        end
        bus.bus_granted = 1'b0;
        tick();
    endtask

    task automatic test_grant_drop();
        logic [15:0] addrs [20];
        logic [15:0] ea;
        int nw, ne, dropped, bad;
        bus.dma_cmd = 1'b1;
        tick();
        bus.dma_cmd = 1'b0;
        bus.bus_granted = 1'b1;
        nw = 0; ne = 0; dropped = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dropped == 1) begin
                n_cmp++;
                if (bus.mem_writeM !== 1'b0 || bus.bus_request !== 1'b1) begin
                    n_err++;
                    $display("FAIL drop_response: wr=%b req=%b required 0/1", bus.mem_writeM, bus.bus_request);
                end
                dropped = 2;
                bus.bus_granted = 1'b1;
            end
            if (bus.mem_writeM === 1'b1) begin
                if (nw < 20) addrs[nw] = bus.mem_address;
                nw++;
            end
            if (bus.dma_end === 1'b1) ne++;
            if (nw == 7 && dropped == 0) begin
                bus.bus_granted = 1'b0;           // 3rd cycle of line 1
                dropped = 1;
            end
        end
        bus.bus_granted = 1'b0;
        n_cmp++;
        if (nw != 15 || ne != 1) begin
            n_err++;
            $display("FAIL drop_counts: writes=%0d ends=%0d required 15/1", nw, ne);
        end
        bad = 0;
        for (int j = 0; j < 15 && j < nw; j++) begin
            ea = (j < 4) ? 16'h01F4 : (j < 11) ? 16'h01F8 : 16'h01FC;
            if (addrs[j] !== ea) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL drop_addresses: %0d write cycles with wrong address, required 0", bad);
        end
    endtask

    task automatic test_spurious_cmd();
        int nw, ne;
        nw = 0; ne = 0;
        bus.dma_cmd = 1'b1;
        tick();
        bus.dma_cmd = 1'b0;
        bus.bus_granted = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.dma_cmd = (i == 3 || i == 4 || i == 8 || i == 12) ? 1'b1 : 1'b0;
            tick();
            if (bus.mem_writeM === 1'b1) nw++;
            if (bus.dma_end === 1'b1) ne++;
            if (bus.bus_request === 1'b0) bus.bus_granted = 1'b0;
        end
        bus.dma_cmd = 1'b0;
        n_cmp++;
        if (nw != 12 || ne != 1) begin
            n_err++;
            $display("FAIL spurious_cmd: writes=%0d ends=%0d required 12/1", nw, ne);
        end
        n_cmp++;
        if (bus.bus_request !== 1'b0) begin
            n_err++;
            $display("FAIL spurious_idle: req=%b required 0", bus.bus_request);
        end
    endtask

    task automatic test_reset_mid();
        int nw, ne, bad;
        bus.dma_cmd = 1'b1;
        tick();
        bus.dma_cmd = 1'b0;
        bus.bus_granted = 1'b1;
        for (int i = 0; i < 6; i++) tick();       // well inside line 1
        Reset_N = 1'b0;
        tick();
        n_cmp++;
        if ({bus.bus_request, bus.dma_end, bus.mem_writeM, bus.mem_address, bus.mem_data, bus.dev_index} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: req=%b end=%b wr=%b addr=%h idx=%0d required all 0",
                     bus.bus_request, bus.dma_end, bus.mem_writeM, bus.mem_address, bus.dev_index);
        end
        Reset_N = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.dma_end !== 1'b0 || bus.bus_request !== 1'b0 || bus.mem_writeM !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL midreset_quiet: %0d active cycles after reset, required 0", bad);
        end
        bus.dma_cmd = 1'b1;
        tick();
        bus.dma_cmd = 1'b0;
        tick();
        n_cmp++;
        if (bus.mem_writeM !== 1'b1 || bus.mem_address !== 16'h01F4 || bus.dev_index !== 2'd0) begin
            n_err++;
            $display("FAIL midreset_restart: wr=%b addr=%h idx=%0d required 1 01f4 0",
                     bus.mem_writeM, bus.mem_address, bus.dev_index);
        end
        nw = 1; ne = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.mem_writeM === 1'b1) nw++;
            if (bus.dma_end === 1'b1) ne++;
            if (bus.bus_request === 1'b0) bus.bus_granted = 1'b0;
        end
        n_cmp++;
        if (nw != 12 || ne != 1) begin
            n_err++;
            $display("FAIL midreset_rerun: writes=%0d ends=%0d required 12/1", nw, ne);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] ea;
        int bad;
        bus2.dma_cmd = 1'b1;
        tick();
        bus2.dma_cmd = 1'b0;
        bus2.bus_granted = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            ea = 16'hFFFC + 16'(4 * (k / 4));
            if (bus2.mem_writeM !== 1'b1 || bus2.mem_address !== ea) begin
                bad++;
                $display("FAIL wrap_addr_k%0d: wr=%b addr=%h required 1 %h", k, bus2.mem_writeM, bus2.mem_address, ea);
            end
        end
        n_cmp++;
        if (bad != 0) n_err++;
        tick();
        n_cmp++;
        if (bus2.dma_end !== 1'b1 || bus2.bus_request !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_done: end=%b req=%b required 1/0", bus2.dma_end, bus2.bus_request);
        end
        bus2.bus_granted = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_delayed_grant();
        test_grant_drop();
        test_spurious_cmd();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
